// File: rtl/irq_priority_encoder.sv
// Sequential priority encoder: captures falling edges on active-low request lines into a
// pending set and grants the highest-numbered pending index over a valid/ack handshake.
module irq_priority_encoder #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] N_REQ,
  input  logic         EN,
  input  logic         ACK,
  output logic [W-1:0] A,
  output logic         VALID,
  output logic         ANY,
  output logic [N-1:0] PENDING,
  output logic         OVF
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_a;
  logic [W-1:0] w_a_nxt;
  logic [N-1:0] r_pending;
  logic [N-1:0] w_pending_nxt;
  logic [N-1:0] r_prev_n_req;
  logic         r_ovf;
  logic [N-1:0] w_ev;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_top;
  logic         w_ovf_set;

  // Highest set bit of the pending register wins; later iterations override earlier ones.
  always_comb begin
    w_top = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_pending[i]) begin
        w_top = W'(i);
      end
    end
  end

  always_comb begin
    w_ev  = r_prev_n_req & ~N_REQ & {N{EN}};
    w_clr = '0;
    if ((r_state == PRESENT) && ACK) begin
      w_clr[r_a] = 1'b1;
    end
    // An event on a bit being cleared keeps it set, so it is not lost.
    w_pending_nxt = w_ev | (r_pending & ~w_clr);
    w_ovf_set     = |(w_ev & r_pending & ~w_clr);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_a_nxt     = w_top;
          w_state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (ACK) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_pending    <= '0;
      r_prev_n_req <= '1;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_a          <= w_a_nxt;
      r_pending    <= w_pending_nxt;
      r_prev_n_req <= N_REQ;
      r_ovf        <= r_ovf | w_ovf_set;
    end
  end

  assign A       = r_a;
  assign VALID   = (r_state == PRESENT);
  assign PENDING = r_pending;
  assign ANY     = |r_pending;
  assign OVF     = r_ovf;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed self-checking bench for irq_priority_encoder with hand-computed expectations.
module tb_irq_priority_encoder;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] N_REQ;
  logic         EN;
  logic         ACK;
  logic [W-1:0] A;
  logic         VALID;
  logic         ANY;
  logic [N-1:0] PENDING;
  logic         OVF;

  int n_checks;
  int n_fail;

  irq_priority_encoder #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .N_REQ  (N_REQ),
    .EN     (EN),
    .ACK    (ACK),
    .A      (A),
    .VALID  (VALID),
    .ANY    (ANY),
    .PENDING(PENDING),
    .OVF    (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic valid, input logic [W-1:0] a,
                           input logic [N-1:0] pend, input logic ovf);
    check({tag, ".valid"}, 32'(VALID), 32'(valid));
    check({tag, ".a"}, 32'(A), 32'(a));
    check({tag, ".pending"}, 32'(PENDING), 32'(pend));
    check({tag, ".any"}, 32'(ANY), 32'(|pend));
    check({tag, ".ovf"}, 32'(OVF), 32'(ovf));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    N_REQ = 8'hFF;
    EN    = 1'b1;
    ACK   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("idle", 1'b0, 3'd0, 8'h00, 1'b0);
    end

    // Single event on bit 3
    N_REQ = 8'hF7;
    tick();
    check_all("single_k", 1'b0, 3'd0, 8'h08, 1'b0);
    tick();
    check_all("single_k1", 1'b1, 3'd3, 8'h08, 1'b0);
    tick();
    check_all("single_k2", 1'b1, 3'd3, 8'h08, 1'b0);
    ACK = 1'b1;
    tick();
    check_all("single_ack", 1'b0, 3'd3, 8'h00, 1'b0);
    ACK   = 1'b0;
    N_REQ = 8'hFF;
    tick();
    check_all("single_after", 1'b0, 3'd3, 8'h00, 1'b0);

    // Priority: bits 1 and 5 together, then bit 7 arrives while 5 is presented
    N_REQ = 8'hDD;
    tick();
    check_all("prio_pend", 1'b0, 3'd3, 8'h22, 1'b0);
    tick();
    check_all("prio_g5", 1'b1, 3'd5, 8'h22, 1'b0);
    N_REQ = 8'h5D;
    tick();
    check_all("prio_nopre", 1'b1, 3'd5, 8'hA2, 1'b0);
    tick();
    check_all("prio_hold", 1'b1, 3'd5, 8'hA2, 1'b0);
    ACK = 1'b1;
    tick();
    check_all("prio_ack5", 1'b0, 3'd5, 8'h82, 1'b0);
    ACK = 1'b0;
    tick();
    check_all("prio_g7", 1'b1, 3'd7, 8'h82, 1'b0);
    ACK = 1'b1;
    tick();
    check_all("prio_ack7", 1'b0, 3'd7, 8'h02, 1'b0);
    ACK = 1'b0;
    tick();
    check_all("prio_g1", 1'b1, 3'd1, 8'h02, 1'b0);
    ACK = 1'b1;
    tick();
    check_all("prio_ack1", 1'b0, 3'd1, 8'h00, 1'b0);
    ACK   = 1'b0;
    N_REQ = 8'hFF;
    tick();

    // Event and clear on the same bit at the same edge
    N_REQ = 8'hFB;
    tick();
    check_all("sim_pend", 1'b0, 3'd1, 8'h04, 1'b0);
    tick();
    check_all("sim_g2", 1'b1, 3'd2, 8'h04, 1'b0);
    N_REQ = 8'hFF;
    tick();
    check_all("sim_rise", 1'b1, 3'd2, 8'h04, 1'b0);
    N_REQ = 8'hFB;
    ACK   = 1'b1;
    tick();
    check_all("sim_evclr", 1'b0, 3'd2, 8'h04, 1'b0);
    ACK = 1'b0;
    tick();
    check_all("sim_regrant", 1'b1, 3'd2, 8'h04, 1'b0);
    ACK = 1'b1;
    tick();
    check_all("sim_ack", 1'b0, 3'd2, 8'h00, 1'b0);
    ACK   = 1'b0;
    N_REQ = 8'hFF;
    tick();

    // Overflow on an already-pending bit
    N_REQ = 8'hEF;
    tick();
    check_all("ovf_pend", 1'b0, 3'd2, 8'h10, 1'b0);
    tick();
    check_all("ovf_g4", 1'b1, 3'd4, 8'h10, 1'b0);
    N_REQ = 8'hFF;
    tick();
    N_REQ = 8'hEF;
    tick();
    check_all("ovf_set", 1'b1, 3'd4, 8'h10, 1'b1);
    ACK = 1'b1;
    tick();
    check_all("ovf_ack", 1'b0, 3'd4, 8'h00, 1'b1);
    ACK   = 1'b0;
    N_REQ = 8'hFF;
    tick();
    check_all("ovf_sticky", 1'b0, 3'd4, 8'h00, 1'b1);

    // EN gating, and re-enable while the line is still low
    EN    = 1'b0;
    N_REQ = 8'hBF;
    tick();
    check_all("en_off", 1'b0, 3'd4, 8'h00, 1'b1);
    tick();
    EN = 1'b1;
    tick();
    check_all("en_reon", 1'b0, 3'd4, 8'h00, 1'b1);
    tick();
    check_all("en_reon2", 1'b0, 3'd4, 8'h00, 1'b1);
    N_REQ = 8'hFF;
    tick();

    // ACK while idle has no effect
    ACK = 1'b1;
    tick();
    check_all("ack_idle", 1'b0, 3'd4, 8'h00, 1'b1);
    ACK = 1'b0;
    tick();

    // Reset mid-handshake with ACK asserted during reset
    N_REQ = 8'hF6;
    tick();
    check_all("rmid_pend", 1'b0, 3'd4, 8'h09, 1'b1);
    tick();
    check_all("rmid_g3", 1'b1, 3'd3, 8'h09, 1'b1);
    rst   = 1'b1;
    ACK   = 1'b1;
    N_REQ = 8'hFF;
    tick();
    check_all("rmid_rst", 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b0;
    ACK = 1'b0;
    tick();
    check_all("rmid_after", 1'b0, 3'd0, 8'h00, 1'b0);
    tick();
    check_all("rmid_after2", 1'b0, 3'd0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
